// File: rtl/bf_pkg.sv
// Shared opcodes, error codes and state encoding for the bracket-matching pass.
package bf_pkg;

    localparam logic [7:0] OP_LBRACK = 8'h5B;
    localparam logic [7:0] OP_RBRACK = 8'h5D;

    typedef enum logic [1:0] {
        ERR_NONE           = 2'd0,
        ERR_UNDERFLOW      = 2'd1,
        ERR_OVERFLOW       = 2'd2,
        ERR_UNMATCHED_OPEN = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_EXAMINE = 3'd2,
        ST_WR2     = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } bm_state_t;

endpackage

// File: rtl/bracket_matcher_addr_stack.sv
// LIFO of program addresses holding the currently open brackets.
// top is combinational and reads as zero while the stack is empty.
module addr_stack #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign top     = empty ? '0 : mem[IW'(count - CW'(1))];

    // Occupancy counter; clear wins over any push/pop request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (do_push) begin
            count <= count + CW'(1);
        end else if (do_pop) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[IW'(count)] <= din;
        end
    end

endmodule

// File: rtl/bracket_matcher.sv
// Post-load scan of program RAM that pairs [ and ] and fills the jump table.
// Each ] produces two single-cycle writes: close->open, then open->close.
module bracket_matcher
    import bf_pkg::*;
#(
    parameter int unsigned PROG_ADDR_WIDTH = 12,
    parameter int unsigned PROG_LEN        = 4095,
    parameter int unsigned STACK_DEPTH     = 64
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    output logic [PROG_ADDR_WIDTH-1:0] prog_rd_addr,
    input  logic [7:0]                 prog_rd_data,
    output logic                       jt_we,
    output logic [PROG_ADDR_WIDTH-1:0] jt_addr,
    output logic [PROG_ADDR_WIDTH-1:0] jt_wr,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [1:0]                 err_code,
    output logic [PROG_ADDR_WIDTH-1:0] err_addr
);

    localparam int unsigned AW = PROG_ADDR_WIDTH;
    localparam logic [AW-1:0] LAST_ADDR = AW'(PROG_LEN);

    bm_state_t   state;
    logic        start_r;
    logic        start_q;
    logic        start_rise;
    logic [AW-1:0] addr;
    logic [AW-1:0] partner;
    logic        done_q;
    logic        error_q;
    err_code_t   err_code_q;
    logic [AW-1:0] err_addr_q;

    logic        st_clear;
    logic        st_push;
    logic        st_pop;
    logic [AW-1:0] st_top;
    logic        st_empty;
    logic        st_full;

    logic        is_lb;
    logic        is_rb;
    logic        at_last;

    assign start_rise = start_r && !start_q;
    assign is_lb      = (prog_rd_data == OP_LBRACK);
    assign is_rb      = (prog_rd_data == OP_RBRACK);
    assign at_last    = (addr == LAST_ADDR);

    assign prog_rd_addr = addr;
    assign busy         = (state == ST_FETCH) || (state == ST_EXAMINE) || (state == ST_WR2);
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign err_addr     = err_addr_q;

    addr_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (AW)
    ) u_stack (
        .clk    (clk),
        .resetn (resetn),
        .clear  (st_clear),
        .push   (st_push),
        .pop    (st_pop),
        .din    (addr),
        .top    (st_top),
        .empty  (st_empty),
        .full   (st_full)
    );

    // Stack control and jump-table write port, decoded from the current state.
    always_comb begin
        st_clear = 1'b0;
        st_push  = 1'b0;
        st_pop   = 1'b0;
        jt_we    = 1'b0;
        jt_addr  = '0;
        jt_wr    = '0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                st_clear = start_rise;
            end
            ST_EXAMINE: begin
                if (is_lb && !st_full) begin
                    st_push = 1'b1;
                end
                if (is_rb && !st_empty) begin
                    st_pop  = 1'b1;
                    jt_we   = 1'b1;
                    jt_addr = addr;
                    jt_wr   = st_top;
                end
            end
            ST_WR2: begin
                jt_we   = 1'b1;
                jt_addr = partner;
                jt_wr   = addr;
            end
            default: ;
        endcase
    end

    // Both start flops reset high so a start held across reset is not a new edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            start_r    <= 1'b1;
            start_q    <= 1'b1;
            addr       <= '0;
            partner    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            err_addr_q <= '0;
        end else begin
            start_r <= start;
            start_q <= start_r;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_rise) begin
                        state      <= ST_FETCH;
                        addr       <= '0;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        err_code_q <= ERR_NONE;
                        err_addr_q <= '0;
                    end
                end
                ST_FETCH: begin
                    state <= ST_EXAMINE;
                end
                ST_EXAMINE: begin
                    if (is_rb) begin
                        if (st_empty) begin
                            state      <= ST_ERROR;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_UNDERFLOW;
                            err_addr_q <= addr;
                        end else begin
                            partner <= st_top;
                            state   <= ST_WR2;
                        end
                    end else if (is_lb && st_full) begin
                        state      <= ST_ERROR;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_OVERFLOW;
                        err_addr_q <= addr;
                    end else if (!at_last) begin
                        addr  <= addr + AW'(1);
                        state <= ST_FETCH;
                    end else if (is_lb) begin
                        // The bracket just pushed is the unmatched top of stack.
                        state      <= ST_ERROR;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_UNMATCHED_OPEN;
                        err_addr_q <= addr;
                    end else if (st_empty) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        state      <= ST_ERROR;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_UNMATCHED_OPEN;
                        err_addr_q <= st_top;
                    end
                end
                ST_WR2: begin
                    if (!at_last) begin
                        addr  <= addr + AW'(1);
                        state <= ST_FETCH;
                    end else if (st_empty) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        state      <= ST_ERROR;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_UNMATCHED_OPEN;
                        err_addr_q <= st_top;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bracket_matcher.sv
// Directed bench: three matcher instances (lengths 2, 4 and 3 bytes) sharing clock and reset.
module tb_bracket_matcher;
    import bf_pkg::*;

    localparam int unsigned AW = 12;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance s1: PROG_LEN=1
    logic          s1_start = 1'b0;
    logic [AW-1:0] s1_rd_addr, s1_jt_addr, s1_jt_wr, s1_err_addr;
    logic [7:0]    s1_rd_data;
    logic          s1_jt_we, s1_busy, s1_done, s1_error;
    logic [1:0]    s1_err_code;
    logic [7:0]    s1_mem [4];
    logic [23:0]   s1_wq [$];
    int            s1_bad = 0;
    int            s1_busy_cnt = 0;

    // Instance s3: PROG_LEN=3
    logic          s3_start = 1'b0;
    logic [AW-1:0] s3_rd_addr, s3_jt_addr, s3_jt_wr, s3_err_addr;
    logic [7:0]    s3_rd_data;
    logic          s3_jt_we, s3_busy, s3_done, s3_error;
    logic [1:0]    s3_err_code;
    logic [7:0]    s3_mem [4];
    logic [23:0]   s3_wq [$];
    int            s3_bad = 0;

    // Instance s2: PROG_LEN=2, STACK_DEPTH=2
    logic          s2_start = 1'b0;
    logic [AW-1:0] s2_rd_addr, s2_jt_addr, s2_jt_wr, s2_err_addr;
    logic [7:0]    s2_rd_data;
    logic          s2_jt_we, s2_busy, s2_done, s2_error;
    logic [1:0]    s2_err_code;
    logic [7:0]    s2_mem [4];
    logic [23:0]   s2_wq [$];
    int            s2_bad = 0;

    bracket_matcher #(.PROG_ADDR_WIDTH(AW), .PROG_LEN(1), .STACK_DEPTH(64)) u_s1 (
        .clk(clk), .resetn(resetn), .start(s1_start),
        .prog_rd_addr(s1_rd_addr), .prog_rd_data(s1_rd_data),
        .jt_we(s1_jt_we), .jt_addr(s1_jt_addr), .jt_wr(s1_jt_wr),
        .busy(s1_busy), .done(s1_done), .error(s1_error),
        .err_code(s1_err_code), .err_addr(s1_err_addr)
    );

    bracket_matcher #(.PROG_ADDR_WIDTH(AW), .PROG_LEN(3), .STACK_DEPTH(64)) u_s3 (
        .clk(clk), .resetn(resetn), .start(s3_start),
        .prog_rd_addr(s3_rd_addr), .prog_rd_data(s3_rd_data),
        .jt_we(s3_jt_we), .jt_addr(s3_jt_addr), .jt_wr(s3_jt_wr),
        .busy(s3_busy), .done(s3_done), .error(s3_error),
        .err_code(s3_err_code), .err_addr(s3_err_addr)
    );

    bracket_matcher #(.PROG_ADDR_WIDTH(AW), .PROG_LEN(2), .STACK_DEPTH(2)) u_s2 (
        .clk(clk), .resetn(resetn), .start(s2_start),
        .prog_rd_addr(s2_rd_addr), .prog_rd_data(s2_rd_data),
        .jt_we(s2_jt_we), .jt_addr(s2_jt_addr), .jt_wr(s2_jt_wr),
        .busy(s2_busy), .done(s2_done), .error(s2_error),
        .err_code(s2_err_code), .err_addr(s2_err_addr)
    );

    // Synchronous program RAM models
    always @(posedge clk) begin
        s1_rd_data <= s1_mem[s1_rd_addr[1:0]];
        s3_rd_data <= s3_mem[s3_rd_addr[1:0]];
        s2_rd_data <= s2_mem[s2_rd_addr[1:0]];
    end

    // Jump-table write logger plus idle-port and done/error exclusivity watch
    always @(negedge clk) begin
        if (s1_jt_we) s1_wq.push_back({s1_jt_addr, s1_jt_wr});
        else if (s1_jt_addr != '0 || s1_jt_wr != '0) s1_bad++;
        if (s1_done && s1_error) s1_bad++;
        if (s1_busy) s1_busy_cnt++;
        if (s3_jt_we) s3_wq.push_back({s3_jt_addr, s3_jt_wr});
        else if (s3_jt_addr != '0 || s3_jt_wr != '0) s3_bad++;
        if (s3_done && s3_error) s3_bad++;
        if (s2_jt_we) s2_wq.push_back({s2_jt_addr, s2_jt_wr});
        else if (s2_jt_addr != '0 || s2_jt_wr != '0) s2_bad++;
        if (s2_done && s2_error) s2_bad++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic finished(input int which);
        case (which)
            1:       return s1_done | s1_error;
            3:       return s3_done | s3_error;
            default: return s2_done | s2_error;
        endcase
    endfunction

    // Caller raises start just after a negedge; the next posedge samples it.
    task automatic wait_end(input int which, output int n);
        n = 0;
        @(posedge clk);
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (finished(which)) break;
        end
    endtask

    initial begin
        int n;
        logic found;

        repeat (3) @(negedge clk);
        check("reset_s1_outputs",
              64'({s1_busy, s1_done, s1_error, s1_err_code, s1_jt_we,
                   s1_jt_addr, s1_jt_wr, s1_err_addr, s1_rd_addr}), 64'd0);
        check("reset_s2_flags", 64'({s2_busy, s2_done, s2_error, s2_err_code}), 64'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // "[]" on PROG_LEN=1
        s1_mem[0] = 8'h5B; s1_mem[1] = 8'h5D;
        s1_wq.delete(); s1_busy_cnt = 0;
        s1_start = 1'b1;
        wait_end(1, n);
        check("pair_latency", 64'(n), 64'd6);
        check("pair_done_err", 64'({s1_done, s1_error, s1_err_code}), 64'b1_0_00);
        check("pair_nwrites", 64'(s1_wq.size()), 64'd2);
        check("pair_w0", 64'(s1_wq[0]), 64'({12'd1, 12'd0}));
        check("pair_w1", 64'(s1_wq[1]), 64'({12'd0, 12'd1}));
        @(negedge clk);
        check("pair_busy_cycles", 64'(s1_busy_cnt), 64'd5);
        s1_start = 1'b0;

        // "[[]]" on PROG_LEN=3
        s3_mem[0] = 8'h5B; s3_mem[1] = 8'h5B; s3_mem[2] = 8'h5D; s3_mem[3] = 8'h5D;
        s3_wq.delete();
        s3_start = 1'b1;
        wait_end(3, n);
        check("nest_latency", 64'(n), 64'd11);
        check("nest_done_err", 64'({s3_done, s3_error, s3_err_code}), 64'b1_0_00);
        check("nest_nwrites", 64'(s3_wq.size()), 64'd4);
        check("nest_w0", 64'(s3_wq[0]), 64'({12'd2, 12'd1}));
        check("nest_w1", 64'(s3_wq[1]), 64'({12'd1, 12'd2}));
        check("nest_w2", 64'(s3_wq[2]), 64'({12'd3, 12'd0}));
        check("nest_w3", 64'(s3_wq[3]), 64'({12'd0, 12'd3}));
        @(negedge clk);
        s3_start = 1'b0;

        // "]+" on PROG_LEN=1: underflow at 0, done from the previous scan cleared
        s1_mem[0] = 8'h5D; s1_mem[1] = 8'h2B;
        repeat (3) @(negedge clk);
        s1_wq.delete();
        s1_start = 1'b1;
        wait_end(1, n);
        check("under_latency", 64'(n), 64'd3);
        check("under_flags", 64'({s1_done, s1_error, s1_err_code}), 64'b0_1_01);
        check("under_addr", 64'(s1_err_addr), 64'd0);
        check("under_nwrites", 64'(s1_wq.size()), 64'd0);
        @(negedge clk);
        s1_start = 1'b0;

        // "+[-" on PROG_LEN=2: unmatched open at 1
        s2_mem[0] = 8'h2B; s2_mem[1] = 8'h5B; s2_mem[2] = 8'h2D;
        s2_wq.delete();
        s2_start = 1'b1;
        wait_end(2, n);
        check("unmatched_latency", 64'(n), 64'd7);
        check("unmatched_flags", 64'({s2_done, s2_error, s2_err_code}), 64'b0_1_11);
        check("unmatched_addr", 64'(s2_err_addr), 64'd1);
        @(negedge clk);
        s2_start = 1'b0;

        // "[[[" with STACK_DEPTH=2: overflow at 2
        s2_mem[0] = 8'h5B; s2_mem[1] = 8'h5B; s2_mem[2] = 8'h5B;
        repeat (3) @(negedge clk);
        s2_start = 1'b1;
        wait_end(2, n);
        check("overflow_latency", 64'(n), 64'd7);
        check("overflow_flags", 64'({s2_done, s2_error, s2_err_code}), 64'b0_1_10);
        check("overflow_addr", 64'(s2_err_addr), 64'd2);
        check("overflow_nwrites", 64'(s2_wq.size()), 64'd0);
        @(negedge clk);
        s2_start = 1'b0;

        // Reset during the WR2 cycle of "[]", start held high across reset
        s1_mem[0] = 8'h5B; s1_mem[1] = 8'h5D;
        repeat (3) @(negedge clk);
        s1_start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s1_jt_we && s1_jt_addr == 12'd0 && s1_jt_wr == 12'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("wr2_reached", 64'(found), 64'd1);
        resetn = 1'b0;
        #1;
        check("midreset_outputs",
              64'({s1_busy, s1_done, s1_error, s1_err_code, s1_jt_we,
                   s1_jt_addr, s1_jt_wr, s1_err_addr, s1_rd_addr}), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        s1_wq.delete(); s1_busy_cnt = 0;
        repeat (10) @(negedge clk);
        check("held_start_no_retrigger",
              64'({s1_busy_cnt[7:0], 4'(s1_wq.size()), s1_done, s1_error}), 64'd0);
        s1_start = 1'b0;
        repeat (3) @(negedge clk);
        s1_start = 1'b1;
        wait_end(1, n);
        check("rescan_latency", 64'(n), 64'd6);
        check("rescan_done", 64'({s1_done, s1_error}), 64'b10);
        check("rescan_w0", 64'(s1_wq[0]), 64'({12'd1, 12'd0}));
        check("rescan_w1", 64'(s1_wq[1]), 64'({12'd0, 12'd1}));
        check("rescan_nwrites", 64'(s1_wq.size()), 64'd2);
        @(negedge clk);
        s1_start = 1'b0;
        repeat (2) @(negedge clk);

        check("idle_port_and_exclusive", 64'(s1_bad + s2_bad + s3_bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bracket_matcher.md
# bracket_matcher

Post-load pass that scans program memory once the program loader finishes and builds the bracket jump table the BF core uses for `[` and `]`. It sits between the loader and the core. It reads program RAM through a dedicated synchronous read port, pairs brackets with a LIFO of addresses, and writes matching partner addresses into the jump-table RAM. The core is held off until `done` is high, and an unbalanced program is flagged on `error`.

## Interface
- PROG_ADDR_WIDTH, 12, program/jump-table address width
- PROG_LEN, 4095, last valid program address; the scan covers 0..PROG_LEN inclusive
- STACK_DEPTH, 64, maximum open-bracket nesting depth
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  level input from the loader's `loaded` flag; each rising edge starts one scan
- prog_rd_addr  out  PROG_ADDR_WIDTH  program RAM read address
- prog_rd_data  in  8  program byte, valid one cycle after `prog_rd_addr`
- jt_we  out  1  jump-table write strobe
- jt_addr  out  PROG_ADDR_WIDTH  jump-table write address
- jt_wr  out  PROG_ADDR_WIDTH  jump-table write data (partner address)
- busy  out  1  scan in progress
- done  out  1  scan completed with balanced brackets; level
- error  out  1  scan aborted; level
- err_code  out  2  0 none, 1 UNDERFLOW, 2 OVERFLOW, 3 UNMATCHED_OPEN
- err_addr  out  PROG_ADDR_WIDTH  address of the offending bracket

## Operation
- States: IDLE, FETCH, EXAMINE, WR2, DONE, ERROR.
- Rising-edge detection of `start` uses a registered copy of the previous `start` value.
  - A rising edge in IDLE, DONE or ERROR moves to FETCH with addr=0.
  - On that transition the stack is emptied and done, error and err_code are cleared.
  - A rising edge seen in FETCH, EXAMINE or WR2 is ignored.
- FETCH:
  - `prog_rd_addr`=addr.
  - Next state is EXAMINE.
- EXAMINE (`prog_rd_data` valid):
  - 0x5B `[`, stack not full: push addr.
  - 0x5B `[`, stack full: go to ERROR with err_code=OVERFLOW and err_addr=addr.
  - 0x5D `]`, stack empty: go to ERROR with err_code=UNDERFLOW and err_addr=addr.
  - 0x5D `]`, stack not empty: pop o into a register. In this same cycle drive jt_we=1, jt_addr=addr, jt_wr=o, then go to WR2.
  - Any other byte: no action.
  - If the byte was not `]` and addr≠PROG_LEN: addr+1, go to FETCH.
  - If the byte was not `]` and addr=PROG_LEN: run the end check.
- WR2:
  - Drive jt_we=1, jt_addr=o, jt_wr=addr.
  - Then advance exactly as a completed EXAMINE does: next address, or the end check.
- End check:
  - Stack empty: go to DONE.
  - Stack not empty: go to ERROR with err_code=UNMATCHED_OPEN and err_addr=top-of-stack.
- Address arithmetic is PROG_ADDR_WIDTH wide. The end test is equality with PROG_LEN, never wrap-around.
- Stack depth is tracked with a counter of width clog2(STACK_DEPTH+1).
  - Full means count==STACK_DEPTH.
  - Push and pop never occur in the same cycle.

## Timing
- Reset values: all outputs 0; state IDLE; stack empty.
- Reset mid-scan aborts immediately. No further jt writes occur, and a new `start` rising edge is required after reset.
- Cycles per byte:
  - Non-`]` byte: 2 cycles (FETCH + EXAMINE).
  - `]`: 3 cycles (FETCH + EXAMINE + WR2).
- Latency: a scan takes 1 + 2·(PROG_LEN+1) + (number of `]`) clock edges from the edge that samples `start` rising to done/error going high. A scan that errors early stops sooner.
- jt_we pulses are single-cycle. For one bracket pair the close write always comes first and the open write follows on the next cycle.
- jt_we, jt_addr and jt_wr are 0 whenever no write is in progress.
- busy=1 exactly in FETCH, EXAMINE and WR2.
- done and error are mutually exclusive and hold until the next accepted `start` rising edge or reset.

## Structure
- Package `bf_pkg`:
  - OP_LBRACK=8'h5B, OP_RBRACK=8'h5D
  - `err_code_t` enum
  - `bm_state_t` enum
- Sub-module `addr_stack`: synchronous LIFO, STACK_DEPTH×PROG_ADDR_WIDTH.
  - Inputs: push, pop, din.
  - Outputs: top (valid when not empty, combinational), empty, full.

## Test plan
- PROG_LEN=1, program "[]", start pulse:
  - jt writes in order (1,0) then (0,1).
  - done rises 6 edges after start is sampled; error=0.
- PROG_LEN=3, program "[[]]":
  - Writes in order (2,1), (1,2), (3,0), (0,3).
  - done=1, err_code=0.
- PROG_LEN=1, program "]+":
  - error=1, err_code=UNDERFLOW, err_addr=0.
  - No jt_we ever asserted.
- PROG_LEN=2, program "+[-":
  - Scan completes, then error with err_code=UNMATCHED_OPEN and err_addr=1.
- STACK_DEPTH=2, PROG_LEN=2, program "[[[":
  - error with err_code=OVERFLOW, err_addr=2.
- Reset during the WR2 of "[]":
  - All outputs 0 on the next cycle and stay idle.
  - A subsequent start rising edge produces a full correct scan; a start held high across reset does not retrigger.
